// File: rtl/alu_result_stage.sv
// Execute-to-writeback register behind the ALU: result capture, architectural flags,
// multi-cycle hold and a valid/ready writeback port. ALU_STALL_COUNT_EN enables stall_cnt.
module alu_result_stage #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned RWIDTH     = 4,
  parameter int unsigned MCP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] alu_dout,
  input  logic              alu_cout,
  input  logic              alu_vout,
  input  logic              alu_qnzout,
  input  logic              alu_mcp,
  input  logic [RWIDTH-1:0] in_rdest,
  input  logic              in_wen,
  input  logic              in_setflags,
  input  logic              in_djnz,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DWIDTH-1:0] wb_data,
  output logic [RWIDTH-1:0] wb_rdest,
  output logic              wb_wen,
  output logic              djnz_taken,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_z,
  output logic              flag_s,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [0:0] {StReady, StMcp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  mcp_cnt_q, mcp_cnt_d;
  logic        space;
  logic        capture;

  assign space   = !wb_valid || wb_ready;
  assign capture = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    mcp_cnt_d = mcp_cnt_q;
    in_ready  = 1'b0;
    unique case (state_q)
      StReady: begin
        if (in_valid && alu_mcp && space) begin
          // The detecting cycle is the first hold cycle, so latency is 1+MCP_CYCLES.
          state_d   = StMcp;
          mcp_cnt_d = 3'(MCP_CYCLES - 1);
        end else begin
          in_ready = space;
        end
      end
      StMcp: begin
        if (mcp_cnt_q != 3'd0) begin
          mcp_cnt_d = mcp_cnt_q - 3'd1;
        end else begin
          in_ready = space;
          if (in_valid && space) state_d = StReady;
        end
      end
      default: state_d = StReady;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StReady;
      mcp_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      mcp_cnt_q <= mcp_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rdest   <= '0;
      wb_wen     <= 1'b0;
      djnz_taken <= 1'b0;
    end else begin
      djnz_taken <= capture && in_djnz && alu_qnzout;
      if (capture) begin
        wb_valid <= 1'b1;
        wb_data  <= alu_dout;
        wb_rdest <= in_rdest;
        wb_wen   <= in_wen;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
    end else if (capture && in_setflags) begin
      flag_c <= alu_cout;
      flag_v <= alu_vout;
      flag_z <= (alu_dout == '0);
      flag_s <= alu_dout[DWIDTH-1];
    end
  end

`ifdef ALU_STALL_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; stall_cnt expectations follow ALU_STALL_COUNT_EN.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] alu_dout;
  logic        alu_cout, alu_vout, alu_qnzout, alu_mcp;
  logic [3:0]  in_rdest;
  logic        in_wen, in_setflags, in_djnz;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rdest;
  logic        wb_wen, djnz_taken;
  logic        flag_c, flag_v, flag_z, flag_s;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

`ifdef ALU_STALL_COUNT_EN
  localparam int StallEn = 1;
`else
  localparam int StallEn = 0;
`endif

  always #5 clk = ~clk;

  alu_result_stage #(.DWIDTH(32), .RWIDTH(4), .MCP_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_dout(alu_dout), .alu_cout(alu_cout), .alu_vout(alu_vout),
    .alu_qnzout(alu_qnzout), .alu_mcp(alu_mcp),
    .in_rdest(in_rdest), .in_wen(in_wen), .in_setflags(in_setflags), .in_djnz(in_djnz),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rdest(wb_rdest), .wb_wen(wb_wen), .djnz_taken(djnz_taken),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_s(flag_s),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] rd,
                       input logic wen, input logic sf, input logic c, input logic vo,
                       input logic mcp, input logic dj, input logic qnz);
    in_valid = v; alu_dout = d; in_rdest = rd; in_wen = wen; in_setflags = sf;
    alu_cout = c; alu_vout = vo; alu_mcp = mcp; in_djnz = dj; alu_qnzout = qnz;
  endtask

  initial begin
    rst = 1'b1;
    wb_ready = 1'b0;
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_flags", {28'd0, flag_c, flag_v, flag_z, flag_s}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // ADD result 5
    wb_ready = 1'b1;
    drive(1, 32'h5, 4'h3, 1, 1, 0, 0, 0, 0, 0);
    #1 check("add_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("add_wb_data", wb_data, 32'h5);
    check("add_wb_rdest", {28'd0, wb_rdest}, 32'h3);
    check("add_wb_wen", {31'd0, wb_wen}, 32'd1);
    check("add_flags_czs", {29'd0, flag_c, flag_z, flag_s}, 32'd0);

    // SUB to zero, no write, carry set; accepted back-to-back
    drive(1, 32'h0, 4'h4, 0, 1, 1, 0, 0, 0, 0);
    #1 check("sub_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("sub_wb_data", wb_data, 32'h0);
    check("sub_wb_wen", {31'd0, wb_wen}, 32'd0);
    check("sub_flags", {28'd0, flag_c, flag_v, flag_z, flag_s}, 32'b1010);

    // Negative result without setflags leaves flags alone
    drive(1, 32'h8000_0000, 4'h5, 1, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("nosf_wb_data", wb_data, 32'h8000_0000);
    check("nosf_flags", {28'd0, flag_c, flag_v, flag_z, flag_s}, 32'b1010);

    drive(1, 32'h8000_0000, 4'h5, 1, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("neg_flags", {28'd0, flag_c, flag_v, flag_z, flag_s}, 32'b0101);

    // alu_mcp without in_valid is ignored; empty slot drains
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0);
    #1 check("idle_mcp_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("drain_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Multi-cycle MUL: one hold cycle, result two cycles after in_valid rises
    drive(1, 32'h1234, 4'h7, 1, 0, 0, 0, 1, 0, 0);
    #1 check("mul_hold_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("mul_accept_in_ready", {31'd0, in_ready}, 32'd1);
    check("mul_wb_valid_early", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("mul_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("mul_wb_data", wb_data, 32'h1234);
    check("mul_stall_cnt", {16'd0, stall_cnt}, 32'(StallEn * 1));

    // Backpressure for three cycles with a new result waiting
    wb_ready = 1'b0;
    drive(1, 32'hAAAA, 4'h2, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_wb_data", wb_data, 32'h1234);
      check("bp_wb_rdest", {28'd0, wb_rdest}, 32'h7);
      @(negedge clk);
    end
    check("bp_stall_cnt", {16'd0, stall_cnt}, 32'(StallEn * 4));
    wb_ready = 1'b1;
    #1 check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp_new_wb_data", wb_data, 32'hAAAA);
    check("bp_stall_hold", {16'd0, stall_cnt}, 32'(StallEn * 4));

    // DJNZ taken, then not taken
    drive(1, 32'h4, 4'h1, 1, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("djnz_taken_pulse", {31'd0, djnz_taken}, 32'd1);
    drive(1, 32'h0, 4'h1, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("djnz_not_taken", {31'd0, djnz_taken}, 32'd0);
    check("djnz_wb_valid", {31'd0, wb_valid}, 32'd1);
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("djnz_idle", {31'd0, djnz_taken}, 32'd0);

    // Reset in the middle of a multi-cycle op
    drive(1, 32'h55, 4'h6, 1, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("mid_rst_wb_data", wb_data, 32'd0);
    check("mid_rst_flags", {28'd0, flag_c, flag_v, flag_z, flag_s}, 32'd0);
    check("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    drive(1, 32'h9, 4'h8, 1, 0, 0, 0, 0, 0, 0);
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("post_rst_wb_data", wb_data, 32'h9);
    check("post_rst_wb_valid1", {31'd0, wb_valid}, 32'd1);
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, required completion before 20000");
    $fatal(1, "timeout");
  end

endmodule
